// File: rtl/i2c_bus_frontend_if.sv
// Pin and event bundle between the raw I2C pins, the bus frontend and the slave FSM.
// The master side drives the pins and consumes events; the slave side is the frontend.
interface i2c_bus_frontend_if;
  logic       SCL;
  logic       iSDA;
  logic       fSCL;
  logic       fSDA;
  logic       SCL_R;
  logic       SCL_F;
  logic       START;
  logic       STOP;
  logic       BUSY;
  logic [3:0] BIT_CNT;
  logic       BYTE_END;
  logic       ACK_SLOT;

  modport master (
    output SCL, iSDA,
    input  fSCL, fSDA, SCL_R, SCL_F, START, STOP, BUSY, BIT_CNT, BYTE_END, ACK_SLOT
  );

  modport slave (
    input  SCL, iSDA,
    output fSCL, fSDA, SCL_R, SCL_F, START, STOP, BUSY, BIT_CNT, BYTE_END, ACK_SLOT
  );
endinterface

// File: rtl/i2c_bus_frontend.sv
// Synchronizes and de-glitches SCL/SDA, then derives registered bus event pulses
// (SCL edges, START, STOP) and a per-frame bit-position tracker.
module i2c_bus_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3
) (
  input logic               CLK,
  input logic               RST_N,
  i2c_bus_frontend_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] FILT_LAST     = CNT_W'(FILTER_LEN - 1);
  localparam logic [BIT_W-1:0] BITS_PER_BYTE = BIT_W'(8);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic [CNT_W-1:0]       scl_cnt_q, scl_cnt_d;
  logic [CNT_W-1:0]       sda_cnt_q, sda_cnt_d;
  logic                   fscl_q, fscl_d;
  logic                   fsda_q, fsda_d;
  logic                   scl_r_q, scl_r_d;
  logic                   scl_f_q, scl_f_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   busy_q, busy_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   byte_end_q, byte_end_d;
  logic                   ack_slot_q, ack_slot_d;
  logic                   scl_tgl_c, sda_tgl_c;

  // Pin synchronizers: newest sample enters at bit 0, synchronized level is the MSB.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.iSDA};
  end

  // Glitch filters: the filtered level flips only after FILTER_LEN consecutive disagreements.
  always_comb begin
    scl_cnt_d = '0;
    sda_cnt_d = '0;
    scl_tgl_c = 1'b0;
    sda_tgl_c = 1'b0;
    if (scl_sync_q[SYNC_STAGES-1] != fscl_q) begin
      if (scl_cnt_q == FILT_LAST) scl_tgl_c = 1'b1;
      else                        scl_cnt_d = scl_cnt_q + CNT_W'(1);
    end
    if (sda_sync_q[SYNC_STAGES-1] != fsda_q) begin
      if (sda_cnt_q == FILT_LAST) sda_tgl_c = 1'b1;
      else                        sda_cnt_d = sda_cnt_q + CNT_W'(1);
    end
    fscl_d = fscl_q ^ scl_tgl_c;
    fsda_d = fsda_q ^ sda_tgl_c;
  end

  // SDA edges are classified against the pre-update fSCL, so a coincident SCL fall still counts.
  always_comb begin
    scl_r_d    = scl_tgl_c & ~fscl_q;
    scl_f_d    = scl_tgl_c &  fscl_q;
    start_d    = sda_tgl_c &  fsda_q & fscl_q;
    stop_d     = sda_tgl_c & ~fsda_q & fscl_q;
    busy_d     = start_d | (busy_q & ~stop_d);
    bit_cnt_d  = bit_cnt_q;
    byte_end_d = 1'b0;
    ack_slot_d = 1'b0;
    if (start_d || stop_d) begin
      bit_cnt_d = '0;
    end else if (scl_r_d && busy_q) begin
      if (bit_cnt_q == BITS_PER_BYTE) begin
        bit_cnt_d  = '0;
        ack_slot_d = 1'b1;
      end else begin
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        byte_end_d = (bit_cnt_q == BITS_PER_BYTE - BIT_W'(1));
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      fscl_q     <= 1'b1;
      fsda_q     <= 1'b1;
      scl_r_q    <= 1'b0;
      scl_f_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      bit_cnt_q  <= '0;
      byte_end_q <= 1'b0;
      ack_slot_q <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      fscl_q     <= fscl_d;
      fsda_q     <= fsda_d;
      scl_r_q    <= scl_r_d;
      scl_f_q    <= scl_f_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_end_q <= byte_end_d;
      ack_slot_q <= ack_slot_d;
    end
  end

  assign bus.fSCL     = fscl_q;
  assign bus.fSDA     = fsda_q;
  assign bus.SCL_R    = scl_r_q;
  assign bus.SCL_F    = scl_f_q;
  assign bus.START    = start_q;
  assign bus.STOP     = stop_q;
  assign bus.BUSY     = busy_q;
  assign bus.BIT_CNT  = bit_cnt_q;
  assign bus.BYTE_END = byte_end_q;
  assign bus.ACK_SLOT = ack_slot_q;

endmodule
